// File: rtl/imem_loader_pkg.sv
// Shared types and default geometry for the instruction-memory loader.
package imem_loader_pkg;

  localparam int BYTE_W            = 8;
  localparam int DEF_I_ADR_WIDTH   = 10;
  localparam int DEF_I_WIDTH       = 20;
  localparam int DEF_I_BUFFER_SIZE = 2;
  localparam int WORD_W            = DEF_I_BUFFER_SIZE * DEF_I_WIDTH;
  localparam int BPW               = (WORD_W + BYTE_W - 1) / BYTE_W;

  typedef enum logic [2:0] {
    IDLE,
    HDR_LO,
    HDR_HI,
    DATA,
    WRITE,
    CHECK,
    DONE
  } state_t;

  function automatic int calc_bpw(input int word_w);
    return (word_w + BYTE_W - 1) / BYTE_W;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
interface imem_loader_if #(
  parameter int I_ADR_WIDTH   = 10,
  parameter int I_WIDTH       = 20,
  parameter int I_BUFFER_SIZE = 2
);
  logic [7:0]                       rx_data;
  logic                             rx_valid;
  logic                             rx_ready;
  logic [I_ADR_WIDTH-1:0]           imem_write_adr;
  logic                             imem_write;
  logic [I_BUFFER_SIZE*I_WIDTH-1:0] imem_in;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_write_adr, imem_write, imem_in
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_write_adr, imem_write, imem_in
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed program from a byte stream into instruction memory while holding
// the core in reset. Define IMEM_LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int I_ADR_WIDTH   = DEF_I_ADR_WIDTH,
  parameter int I_WIDTH       = DEF_I_WIDTH,
  parameter int I_BUFFER_SIZE = DEF_I_BUFFER_SIZE
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         core_reset,
  output logic         busy,
  output logic         done,
  output logic         error
);

  localparam int MEM_W  = I_BUFFER_SIZE * I_WIDTH;
  localparam int NBYTES = calc_bpw(MEM_W);
  localparam int ASM_W  = NBYTES * BYTE_W;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t                 state_q, state_d;
  logic [I_ADR_WIDTH-1:0] count_q, count_d;
  logic [I_ADR_WIDTH-1:0] adr_q, adr_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [ASM_W-1:0]       asm_q, asm_d;
  logic [MEM_W-1:0]       imem_in_q, imem_in_d;
  logic                   core_reset_q, core_reset_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic                   rx_ready;
  logic                   rx_fire;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]             csum_q, csum_d;
`endif

  always_comb begin
    rx_ready = 1'b0;
    case (state_q)
      HDR_LO, HDR_HI, DATA: rx_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK:                rx_ready = 1'b1;
`endif
      default:              rx_ready = 1'b0;
    endcase
  end

  assign rx_fire = rx_ready & bus.rx_valid;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    adr_d        = adr_q;
    idx_d        = idx_q;
    asm_d        = asm_q;
    imem_in_d    = imem_in_q;
    core_reset_d = core_reset_q;
    busy_d       = busy_q;
    done_d       = done_q;
    error_d      = error_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = HDR_LO;
          adr_d        = '0;
          idx_d        = '0;
          core_reset_d = 1'b1;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          error_d      = 1'b0;
        end
      end
      HDR_LO: begin
        if (rx_fire) begin
          count_d[7:0] = bus.rx_data;
          state_d      = HDR_HI;
        end
      end
      // Header high byte supplies only the bits above 7; the rest of the byte is padding.
      HDR_HI: begin
        if (rx_fire) begin
          count_d[I_ADR_WIDTH-1:8] = bus.rx_data[I_ADR_WIDTH-9:0];
          state_d = (count_d == '0) ? CHECK : DATA;
        end
      end
      DATA: begin
        if (rx_fire) begin
          asm_d[idx_q*BYTE_W +: BYTE_W] = bus.rx_data;
          if (idx_q == LAST_IDX) begin
            idx_d     = '0;
            imem_in_d = asm_d[MEM_W-1:0];
            state_d   = WRITE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      // The address doubles as the words-written counter, so it stops at count and never wraps.
      WRITE: begin
        adr_d   = adr_q + 1'b1;
        state_d = (adr_d == count_q) ? CHECK : DATA;
      end
      CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (rx_fire) begin
          state_d      = DONE;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          error_d      = (bus.rx_data != csum_q);
          core_reset_d = error_d;
        end
`else
        state_d      = DONE;
        busy_d       = 1'b0;
        done_d       = 1'b1;
        core_reset_d = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_comb begin
    csum_d = csum_q;
    if ((state_q == IDLE || state_q == DONE) && start) begin
      csum_d = '0;
    end else if (rx_fire && state_q != CHECK) begin
      csum_d = csum_q ^ bus.rx_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) csum_q <= '0;
    else       csum_q <= csum_d;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      adr_q        <= '0;
      idx_q        <= '0;
      imem_in_q    <= '0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      adr_q        <= adr_d;
      idx_q        <= idx_d;
      imem_in_q    <= imem_in_d;
      core_reset_q <= core_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  // Assembly buffer is pure data; every byte lane is overwritten before it is used.
  always_ff @(posedge clk) begin
    asm_q <= asm_d;
  end

  assign bus.rx_ready       = rx_ready;
  assign bus.imem_write     = (state_q == WRITE);
  assign bus.imem_write_adr = adr_q;
  assign bus.imem_in        = imem_in_q;
  assign core_reset         = core_reset_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign error              = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a byte-stream reference model.
module tb_imem_loader;

  localparam int AW = 10;
  localparam int IW = 20;
  localparam int IB = 2;
  localparam int WW = IW * IB;
  localparam int NB = (WW + 7) / 8;

  typedef struct {
    logic [AW-1:0] adr;
    logic [WW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset, start;
  logic core_reset, busy, done, error;

  imem_loader_if #(.I_ADR_WIDTH(AW), .I_WIDTH(IW), .I_BUFFER_SIZE(IB)) bus ();

  imem_loader #(.I_ADR_WIDTH(AW), .I_WIDTH(IW), .I_BUFFER_SIZE(IB)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus.slave),
    .core_reset (core_reset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  wr_t         exp_q[$];
  wr_t         log_q[$];
  logic [7:0]  prog[$];
  logic [WW-1:0] last_word = '0;
  int          exp_count = 0;
  int          byte_i = 0;
  bit          wr_due = 0;
  bit          loading = 0;
  bit          starting = 0;
  bit          exp_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Per-cycle checker: write strobe timing, write contents, data stability and reset values.
  always @(negedge clk) begin : monitor
    wr_t e;
    wr_t o;
    if (reset) begin
      chk("rst_imem_write", bus.imem_write, 0);
      chk("rst_imem_in", bus.imem_in, 0);
      chk("rst_imem_adr", bus.imem_write_adr, 0);
      chk("rst_rx_ready", bus.rx_ready, 0);
      chk("rst_core_reset", core_reset, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      exp_q.delete();
      last_word = '0;
      byte_i    = 0;
      wr_due    = 0;
    end else begin
      chk("imem_write_timing", bus.imem_write, wr_due);
      if (bus.imem_write) begin
        chk("write_rx_ready", bus.rx_ready, 0);
        o.adr  = bus.imem_write_adr;
        o.data = bus.imem_in;
        log_q.push_back(o);
        chk("write_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("write_adr", bus.imem_write_adr, e.adr);
          chk("write_data", bus.imem_in, e.data);
          last_word = e.data;
        end
      end else begin
        chk("imem_in_stable", bus.imem_in, last_word);
      end
      if (!loading) chk("idle_rx_ready", bus.rx_ready, 0);
      if (starting) byte_i = 0;
      wr_due = 0;
      if (bus.rx_valid && bus.rx_ready) begin
        if (byte_i >= 2 && byte_i < 2 + exp_count * NB && ((byte_i - 2) % NB) == NB - 1)
          wr_due = 1;
        byte_i++;
      end
    end
  end

  // Program image: two header bytes, count*NB data bytes, optional checksum byte.
  task automatic build_prog(input int cnt, input bit rnd, input bit junk, input bit bad_csum);
    logic [7:0] cs;
    logic [7:0] hi;
    prog.delete();
    hi = 8'(cnt >> 8) & 8'h03;
    if (junk) hi = hi | (8'($urandom_range(0, 63)) << 2);
    prog.push_back(8'(cnt));
    prog.push_back(hi);
    for (int i = 0; i < cnt * NB; i++)
      prog.push_back(rnd ? 8'($urandom_range(0, 255)) : 8'(i + 1));
    cs = 8'h00;
    foreach (prog[i]) cs = cs ^ prog[i];
`ifdef IMEM_LOADER_CHECKSUM_EN
    prog.push_back(bad_csum ? (cs ^ 8'h01) : cs);
    exp_err = bad_csum;
`else
    exp_err = 1'b0;
    if (bad_csum && cs == 8'h00) exp_err = 1'b0;
`endif
    exp_count = cnt;
  endtask

  // vmode: 0 always valid, 1 valid every other cycle, 2 random valid with stray starts.
  task automatic run_load(input int vmode, input int abort_at);
    int  guard;
    bit  sent;
    bit  v;
    bit  tog;
    logic [63:0] word;
    wr_t e;
    log_q.delete();
    exp_q.delete();
    for (int w = 0; w < exp_count; w++) begin
      word = '0;
      for (int k = 0; k < NB; k++) word = word | (64'(prog[2 + w * NB + k]) << (8 * k));
      e.adr  = AW'(w);
      e.data = WW'(word);
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    loading = 1; starting = 1; start = 1;
    @(posedge clk); #1;
    starting = 0; start = 0;
    chk("start_busy", busy, 1);
    chk("start_core_reset", core_reset, 1);
    chk("start_done", done, 0);
    chk("start_error", error, 0);
    tog = 1;
    for (int i = 0; i < prog.size(); i++) begin
      if (i == abort_at) begin
        bus.rx_valid = 0;
        start = 0;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        loading = 0;
        return;
      end
      sent  = 0;
      guard = 0;
      while (!sent) begin
        case (vmode)
          0:       v = 1;
          1:       begin v = tog; tog = ~tog; end
          default: v = ($urandom_range(0, 3) != 0);
        endcase
        bus.rx_valid = v;
        bus.rx_data  = v ? prog[i] : 8'($urandom_range(0, 255));
        start = (vmode == 2) && ($urandom_range(0, 7) == 0);
        @(negedge clk);
        if (v && bus.rx_ready) sent = 1;
        @(posedge clk); #1;
        guard++;
        if (!sent && guard > 200) begin
          chk("byte_accept_timeout", 0, 1);
          bus.rx_valid = 0; start = 0; loading = 0;
          return;
        end
      end
    end
    bus.rx_valid = 0;
    start = 0;
    guard = 0;
    while (done !== 1'b1 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    loading = 0;
    chk("load_done", done, 1);
    chk("load_busy", busy, 0);
    chk("load_core_reset", core_reset, exp_err);
    chk("load_error", error, exp_err);
    chk("writes_outstanding", exp_q.size(), 0);
  endtask

  task automatic pin_seq_load();
    chk("pin_nwrites", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("pin_adr0", log_q[0].adr, 0);
      chk("pin_data0", log_q[0].data, 40'h0504030201);
      chk("pin_adr1", log_q[1].adr, 1);
      chk("pin_data1", log_q[1].data, 40'h0A09080706);
    end
  endtask

  initial begin
    reset = 1; start = 0;
    bus.rx_valid = 0; bus.rx_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 0;

    repeat (20) begin
      @(negedge clk);
      chk("noload_core_reset", core_reset, 1);
      chk("noload_rx_ready", bus.rx_ready, 0);
      chk("noload_done", done, 0);
      chk("noload_busy", busy, 0);
    end

    build_prog(2, 0, 0, 0);
    run_load(0, -1);
    pin_seq_load();

    build_prog(2, 0, 0, 0);
    run_load(1, -1);
    pin_seq_load();

    build_prog(0, 0, 0, 0);
    run_load(0, -1);
    chk("empty_nwrites", log_q.size(), 0);

    build_prog(2, 0, 0, 0);
    run_load(0, 5);
    repeat (3) @(posedge clk);
    #1;
    build_prog(2, 0, 0, 0);
    run_load(0, -1);
    pin_seq_load();

`ifdef IMEM_LOADER_CHECKSUM_EN
    build_prog(2, 0, 0, 1);
    run_load(0, -1);
    build_prog(3, 1, 1, 0);
    run_load(2, -1);
`endif

    repeat (10) begin
      build_prog($urandom_range(0, 12), 1, 1, 0);
      run_load(2, -1);
      chk("rand_nwrites", log_q.size(), exp_count);
    end

    build_prog((1 << AW) - 1, 1, 1, 0);
    run_load(0, -1);
    chk("max_nwrites", log_q.size(), (1 << AW) - 1);
    if (log_q.size() > 0) begin
      chk("max_first_adr", log_q[0].adr, 0);
      chk("max_last_adr", log_q[log_q.size() - 1].adr, 10'h3FE);
    end

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
